// File: rtl/sbox_layer_serial_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sbox_layer_serial_if
// Brief    : 64-bit state stream (valid/ready) used on both sides of the
//            serial S-box layer. Bit 0 of state is the MSB.
// Revision : 1.0  initial release
// ============================================================================
interface sbox_layer_serial_if;
   logic        valid;
   logic        ready;
   logic [0:63] state;

   modport master (output valid, output state, input ready);
   modport slave  (input valid, input state, output ready);
endinterface
`default_nettype wire

// File: rtl/sbox_layer_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sbox_layer_serial
// Brief    : Iterative 64-bit S-box layer, NIB_PER_CYCLE nibbles per clock
//            through one shared table, valid/ready on input and output.
// Revision : 1.0  initial release
// ============================================================================
module sbox_layer_serial #(
   parameter int          NIB_PER_CYCLE = 1,
   parameter logic [63:0] SBOX_TABLE    = 64'hC56B90AD3EF84712
) (
   input  logic                     clk,
   input  logic                     rst,
   sbox_layer_serial_if.slave       in_if,
   sbox_layer_serial_if.master      out_if,
   output logic                     busy
);

   generate
      if (!(NIB_PER_CYCLE == 1 || NIB_PER_CYCLE == 2 || NIB_PER_CYCLE == 4 ||
            NIB_PER_CYCLE == 8 || NIB_PER_CYCLE == 16)) begin : g_bad_nib_per_cycle
         $error("sbox_layer_serial: NIB_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_busy = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   // With 16 nibbles per cycle the step wraps to 0 and the last count is 0.
   localparam logic [3:0] c_step     = 4'(NIB_PER_CYCLE);
   localparam logic [3:0] c_last_cnt = 4'(16 - NIB_PER_CYCLE);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [0:63] work_q, work_d;
   logic        w_in_rdy;
   logic        w_load;

   // S(x) sits at bits [63-4x -: 4]; 63-4x equals {~x, 2'b11}.
   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TABLE[{~x, 2'b11} -: 4];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_idle;
         cnt_q   <= 4'd0;
         work_q  <= 64'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle:  if (w_load) state_d = c_busy;
         c_busy:  if (cnt_q == c_last_cnt) state_d = c_done;
         c_done: begin
            if (w_load)
               state_d = c_busy;
            else if (out_if.ready)
               state_d = c_idle;
         end
         default: state_d = c_idle;
      endcase
   end

   always_comb begin
      w_in_rdy     = (state_q == c_idle) || ((state_q == c_done) && out_if.ready);
      w_load       = w_in_rdy && in_if.valid;
      in_if.ready  = w_in_rdy;
      out_if.valid = (state_q == c_done);
      out_if.state = work_q;
      busy         = (state_q == c_busy);
   end

   always_comb begin
      cnt_d  = cnt_q;
      work_d = work_q;
      if (w_load) begin
         work_d = in_if.state;
         cnt_d  = 4'd0;
      end else if (state_q == c_busy) begin
         for (int i = 0; i < NIB_PER_CYCLE; i++) begin
            work_d[{cnt_q + 4'(i), 2'b00} +: 4] = sbox(work_q[{cnt_q + 4'(i), 2'b00} +: 4]);
         end
         cnt_d = cnt_q + c_step;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sbox_layer_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sbox_layer_serial
// Brief    : Directed and randomized bench for sbox_layer_serial with a
//            table-lookup reference model; four instances with different
//            widths/tables share one stimulus port selected by sel.
// Revision : 1.0  initial release
// ============================================================================
module tb_sbox_layer_serial;

   localparam logic [63:0] DEF_TABLE = 64'hC56B90AD3EF84712;
   localparam logic [63:0] ID_TABLE  = 64'h0123456789ABCDEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic        in_valid = 1'b0;
   logic [63:0] in_state = 64'h0;
   logic        out_ready = 1'b1;

   logic        obs_in_ready, obs_out_valid, obs_busy;
   logic [63:0] obs_out_state;
   logic        busy0, busy1, busy2, busy3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sbox_layer_serial_if in0(), out0(), in1(), out1(), in2(), out2(), in3(), out3();

   assign in0.valid = in_valid && (sel == 2'd0);
   assign in1.valid = in_valid && (sel == 2'd1);
   assign in2.valid = in_valid && (sel == 2'd2);
   assign in3.valid = in_valid && (sel == 2'd3);
   assign in0.state = in_state;
   assign in1.state = in_state;
   assign in2.state = in_state;
   assign in3.state = in_state;
   assign out0.ready = (sel == 2'd0) ? out_ready : 1'b1;
   assign out1.ready = (sel == 2'd1) ? out_ready : 1'b1;
   assign out2.ready = (sel == 2'd2) ? out_ready : 1'b1;
   assign out3.ready = (sel == 2'd3) ? out_ready : 1'b1;

   sbox_layer_serial #(.NIB_PER_CYCLE(1),  .SBOX_TABLE(DEF_TABLE)) u_dut_n1
      (.clk(clk), .rst(rst), .in_if(in0), .out_if(out0), .busy(busy0));
   sbox_layer_serial #(.NIB_PER_CYCLE(4),  .SBOX_TABLE(DEF_TABLE)) u_dut_n4
      (.clk(clk), .rst(rst), .in_if(in1), .out_if(out1), .busy(busy1));
   sbox_layer_serial #(.NIB_PER_CYCLE(16), .SBOX_TABLE(DEF_TABLE)) u_dut_n16
      (.clk(clk), .rst(rst), .in_if(in2), .out_if(out2), .busy(busy2));
   sbox_layer_serial #(.NIB_PER_CYCLE(2),  .SBOX_TABLE(ID_TABLE))  u_dut_id
      (.clk(clk), .rst(rst), .in_if(in3), .out_if(out3), .busy(busy3));

   always_comb begin
      obs_in_ready  = in0.ready;
      obs_out_valid = out0.valid;
      obs_out_state = out0.state;
      obs_busy      = busy0;
      case (sel)
         2'd1: begin
            obs_in_ready = in1.ready; obs_out_valid = out1.valid;
            obs_out_state = out1.state; obs_busy = busy1;
         end
         2'd2: begin
            obs_in_ready = in2.ready; obs_out_valid = out2.valid;
            obs_out_state = out2.state; obs_busy = busy2;
         end
         2'd3: begin
            obs_in_ready = in3.ready; obs_out_valid = out3.valid;
            obs_out_state = out3.state; obs_busy = busy3;
         end
         default: ;
      endcase
   end

   // Reference: expand the table into a 16-entry array and look each nibble up.
   function automatic logic [63:0] ref_sub(input logic [63:0] s, input logic [63:0] tbl);
      logic [3:0]  sb [16];
      logic [63:0] r;
      for (int x = 0; x < 16; x++) sb[x] = tbl[63 - 4*x -: 4];
      for (int n = 0; n < 16; n++) r[63 - 4*n -: 4] = sb[s[63 - 4*n -: 4]];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input logic [1:0] s, input logic [63:0] din,
                          input logic [63:0] exp, input int lat_exp, input string tag);
      int lat;
      sel = s; out_ready = 1'b1; in_state = din; in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(obs_in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!obs_out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
      check({tag, "_out_state"}, obs_out_state, exp);
      tick();
      check({tag, "_idle_in_ready"}, 64'(obs_in_ready), 64'd1);
      check({tag, "_idle_out_valid"}, 64'(obs_out_valid), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          sent;
      int          got;
      logic        seen;
      logic [63:0] d;
      logic [63:0] q[$];

      // Reset state of every instance
      tick(); tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sel = 2'(k);
         #1;
         check("rst_in_ready", 64'(obs_in_ready), 64'd1);
         check("rst_out_valid", 64'(obs_out_valid), 64'd0);
         check("rst_busy", 64'(obs_busy), 64'd0);
         check("rst_out_state", obs_out_state, 64'h0);
      end

      // Directed vectors and latency per width
      run_one(2'd0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 16, "n1_ramp");
      run_one(2'd0, 64'h0, 64'hCCCCCCCCCCCCCCCC, 16, "n1_zero");
      run_one(2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222, 16, "n1_ones");
      run_one(2'd1, 64'h0, 64'hCCCCCCCCCCCCCCCC, 4, "n4_zero");
      run_one(2'd1, 64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222, 4, "n4_ones");
      run_one(2'd2, 64'h0, 64'hCCCCCCCCCCCCCCCC, 1, "n16_zero");
      run_one(2'd2, 64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222, 1, "n16_ones");

      // Backpressure: hold result 10 cycles, ignore toggling in_valid
      sel = 2'd0; out_ready = 1'b0; in_state = 64'h0123456789ABCDEF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!obs_out_valid && lat < 40) begin tick(); lat++; end
      check("bp_latency", 64'(lat), 64'd16);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_state = {$urandom, $urandom};
         #1;
         check("bp_out_valid", 64'(obs_out_valid), 64'd1);
         check("bp_out_state", obs_out_state, 64'hC56B90AD3EF84712);
         check("bp_in_ready", 64'(obs_in_ready), 64'd0);
         tick();
      end
      in_valid = 1'b1; in_state = 64'hFEDCBA9876543210; out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(obs_in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("bp_reload_busy", 64'(obs_busy), 64'd1);
      lat = 0;
      while (!obs_out_valid && lat < 40) begin tick(); lat++; end
      check("bp_reload_latency", 64'(lat), 64'd16);
      check("bp_reload_out_state", obs_out_state, 64'h21748FE3DA09B65C);
      tick();

      // Reset at BUSY cycle 7
      sel = 2'd0; in_state = 64'h0123456789ABCDEF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      check("mid_busy", 64'(obs_busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_in_ready", 64'(obs_in_ready), 64'd1);
      check("mid_rst_out_valid", 64'(obs_out_valid), 64'd0);
      check("mid_rst_busy", 64'(obs_busy), 64'd0);
      check("mid_rst_out_state", obs_out_state, 64'h0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen = seen | obs_out_valid;
         tick();
      end
      check("mid_rst_no_stale", 64'(seen), 64'd0);
      run_one(2'd0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 16, "post_rst");

      // Random streaming with stalls on both sides, NIB_PER_CYCLE=4
      sel = 2'd1; in_valid = 1'b0; out_ready = 1'b1;
      sent = 0; got = 0;
      for (int cyc = 0; cyc < 30000 && (sent < 1000 || q.size() > 0); cyc++) begin
         logic acc;
         if (!in_valid && sent < 1000 && $urandom_range(0, 9) < 6) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom};
         end
         out_ready = ($urandom_range(0, 9) < 6);
         #1;
         if (obs_out_valid && out_ready) begin
            got++;
            if (q.size() == 0)
               check("stream_extra_output", 64'(got), 64'(sent));
            else
               check("stream_out_state", obs_out_state, q.pop_front());
         end
         acc = in_valid && obs_in_ready;
         if (acc) begin
            q.push_back(ref_sub(in_state, DEF_TABLE));
            sent++;
         end
         tick();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_sent", 64'(sent), 64'd1000);
      check("stream_received", 64'(got), 64'd1000);
      check("stream_queue_empty", 64'(q.size()), 64'd0);
      tick(); tick();

      // Identity table returns the input unchanged
      for (int i = 0; i < 12; i++) begin
         d = {$urandom, $urandom};
         run_one(2'd3, d, d, 8, "identity");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
